// File: rtl/frame_windower.sv
// Overlapping frame buffer with Hamming window; emits each N-sample frame as one
// contiguous burst for the SDF FFT input stage, with at least one idle cycle between frames.
module frame_windower #(
  parameter int unsigned N      = 64,
  parameter int unsigned HOP    = 32,
  parameter int unsigned WIDTH  = 16,
  parameter bit          WIN_EN = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    s_valid,
  input  logic signed [WIDTH-1:0] s_data,
  output logic                    s_ready,
  output logic                    do_en,
  output logic signed [WIDTH-1:0] do_re,
  output logic signed [WIDTH-1:0] do_im,
  output logic                    do_start,
  output logic                    ovf
);

  localparam int unsigned D  = N + HOP;
  localparam int unsigned AW = $clog2(D);
  localparam int unsigned KW = $clog2(N);
  localparam int unsigned OW = $clog2(D + 1);
  localparam int unsigned PW = WIDTH + 17;
  localparam real Pi = 3.14159265358979323846;
  localparam logic signed [PW-1:0] RndHalf = PW'(16384);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  function automatic logic [15:0] hamming(input int k);
    real c;
    c = 32767.0 * (0.54 - 0.46 * $cos(2.0 * Pi * real'(k) / real'(N - 1)));
    return 16'($rtoi(c + 0.5));
  endfunction

  logic [15:0] win_rom [N];
  for (genvar g = 0; g < N; g++) begin : g_rom
    assign win_rom[g] = hamming(g);
  end

  logic signed [WIDTH-1:0] mem [D];

  state_e                  state_q, state_d;
  logic [KW-1:0]           k_q, k_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_base_q, rd_base_d;
  logic [OW-1:0]           occ_q, occ_d;
  logic                    ovf_q, ovf_d;
  logic                    rd_vld_q, rd_vld_d;
  logic                    first_q, first_d;
  logic signed [WIDTH-1:0] rd_data_q, rd_data_d;
  logic [15:0]             coef_q, coef_d;
  logic                    do_en_q, do_en_d;
  logic                    do_start_q, do_start_d;
  logic signed [WIDTH-1:0] do_re_q, do_re_d;

  logic                    wr_en, rel;
  logic [AW:0]             rd_sum, base_sum;
  logic [AW-1:0]           rd_addr;
  logic signed [PW-1:0]    samp_ext, coef_ext, prod, prod_rnd;
  logic signed [WIDTH-1:0] win_val;

  assign s_ready = (occ_q < OW'(D));
  assign wr_en   = s_valid & s_ready;

  // Pointers wrap explicitly: D is generally not a power of two.
  always_comb begin
    rd_sum   = {1'b0, rd_base_q} + (AW+1)'(k_q);
    rd_addr  = (rd_sum >= (AW+1)'(D)) ? AW'(rd_sum - (AW+1)'(D)) : AW'(rd_sum);
    base_sum = {1'b0, rd_base_q} + (AW+1)'(HOP);
    wr_ptr_d = wr_en ? ((wr_ptr_q == AW'(D - 1)) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    rd_base_d = rd_base_q;
    rel       = 1'b0;
    rd_vld_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (occ_q >= OW'(N)) begin
          state_d = StEmit;
          k_d     = '0;
        end
      end
      StEmit: begin
        rd_vld_d = 1'b1;
        k_d      = k_q + 1'b1;
        if (k_q == KW'(N - 1)) begin
          state_d   = StIdle;
          rel       = 1'b1;
          rd_base_d = (base_sum >= (AW+1)'(D)) ? AW'(base_sum - (AW+1)'(D)) : AW'(base_sum);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    occ_d     = occ_q + OW'(wr_en) - (rel ? OW'(HOP) : '0);
    ovf_d     = ovf_q | (s_valid & ~s_ready);
    first_d   = (k_q == '0);
    rd_data_d = mem[rd_addr];
    coef_d    = win_rom[k_q];
  end

  // Q1.15 multiply, round half up, then truncate back to WIDTH.
  always_comb begin
    samp_ext   = PW'(rd_data_q);
    coef_ext   = PW'(coef_q);
    prod       = samp_ext * coef_ext;
    prod_rnd   = prod + RndHalf;
    win_val    = WIDTH'(prod_rnd >>> 15);
    do_en_d    = rd_vld_q;
    do_start_d = rd_vld_q & first_q;
    do_re_d    = '0;
    if (rd_vld_q) do_re_d = WIN_EN ? win_val : rd_data_q;
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr_q] <= s_data;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= StIdle;
      k_q        <= '0;
      wr_ptr_q   <= '0;
      rd_base_q  <= '0;
      occ_q      <= '0;
      ovf_q      <= 1'b0;
      rd_vld_q   <= 1'b0;
      first_q    <= 1'b0;
      rd_data_q  <= '0;
      coef_q     <= '0;
      do_en_q    <= 1'b0;
      do_start_q <= 1'b0;
      do_re_q    <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_base_q  <= rd_base_d;
      occ_q      <= occ_d;
      ovf_q      <= ovf_d;
      rd_vld_q   <= rd_vld_d;
      first_q    <= first_d;
      rd_data_q  <= rd_data_d;
      coef_q     <= coef_d;
      do_en_q    <= do_en_d;
      do_start_q <= do_start_d;
      do_re_q    <= do_re_d;
    end
  end

  assign do_en    = do_en_q;
  assign do_start = do_start_q;
  assign do_re    = do_re_q;
  assign do_im    = '0;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_frame_windower.sv
// Directed bench for frame_windower: a pass-through and a windowed instance share the
// stimulus; a cycle-level control model checks handshake/burst timing on every cycle.
module tb_frame_windower;
  localparam int N   = 64;
  localparam int HOP = 32;
  localparam int D   = N + HOP;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               s_valid = 1'b0;
  logic signed [15:0] s_data = '0;
  logic               mon_en = 1'b0;

  logic               pt_ready, pt_en, pt_start, pt_ovf;
  logic signed [15:0] pt_re, pt_im;
  logic               win_ready, win_en, win_start, win_ovf;
  logic signed [15:0] win_re, win_im;

  always #5 clk = ~clk;

  frame_windower #(.N(N), .HOP(HOP), .WIDTH(16), .WIN_EN(1'b0)) u_pt (
    .clock(clk), .reset(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(pt_ready),
    .do_en(pt_en), .do_re(pt_re), .do_im(pt_im), .do_start(pt_start), .ovf(pt_ovf)
  );

  frame_windower #(.N(N), .HOP(HOP), .WIDTH(16), .WIN_EN(1'b1)) u_win (
    .clock(clk), .reset(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(win_ready),
    .do_en(win_en), .do_re(win_re), .do_im(win_im), .do_start(win_start), .ovf(win_ovf)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Control model: occupancy, IDLE/EMIT state, read index, 2-stage output pipeline.
  int  m_occ = 0, m_k = 0;
  bit  m_state = 0, m_ovf = 0, m_wr, m_rel;
  bit  e1 = 0, e2 = 0, s1 = 0, s2 = 0;
  int  acc_q[$];
  int  pt_vals[$];
  int  win_vals[$];

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_occ = 0; m_k = 0; m_state = 0; m_ovf = 0;
      e1 = 0; e2 = 0; s1 = 0; s2 = 0;
      acc_q.delete(); pt_vals.delete(); win_vals.delete();
    end else begin
      m_wr  = s_valid && (m_occ < D);
      m_rel = m_state && (m_k == N - 1);
      if (s_valid && !(m_occ < D)) m_ovf = 1'b1;
      if (m_wr) acc_q.push_back(int'(s_data));
      e2 = e1; s2 = s1;
      e1 = m_state; s1 = m_state && (m_k == 0);
      if (!m_state) begin
        if (m_occ >= N) begin m_state = 1'b1; m_k = 0; end
      end else if (m_rel) begin
        m_state = 1'b0; m_k = 0;
      end else begin
        m_k++;
      end
      m_occ = m_occ + int'(m_wr) - (m_rel ? HOP : 0);
    end
  end

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      check("s_ready", int'(pt_ready), int'(m_occ < D));
      check("do_en", int'(pt_en), int'(e2));
      check("do_start", int'(pt_start), int'(s2));
      check("ovf", int'(pt_ovf), int'(m_ovf));
      check("do_im", int'(pt_im), 0);
      check("win_s_ready", int'(win_ready), int'(m_occ < D));
      check("win_do_en", int'(win_en), int'(e2));
      check("win_do_start", int'(win_start), int'(s2));
      check("win_ovf", int'(win_ovf), int'(m_ovf));
      check("win_do_im", int'(win_im), 0);
      if (pt_en) pt_vals.push_back(int'(pt_re));
      if (win_en) win_vals.push_back(int'(win_re));
    end
  end

  task automatic send(input logic signed [15:0] v);
    int n = 0;
    @(negedge clk);
    while (!pt_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", int'(pt_ready), 1);
    s_valid = 1'b1;
    s_data  = v;
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int nf, na, n;

  initial begin
    repeat (5) @(posedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset
    repeat (20) @(negedge clk);
    check("idle_ready", int'(pt_ready), 1);
    check("idle_en", int'(pt_en), 0);
    check("idle_ovf", int'(pt_ovf), 0);

    // Pass-through: 1..64 then 65..96
    for (int i = 1; i <= 64; i++) send(16'(i));
    repeat (100) @(negedge clk);
    check("pt_f0_len", pt_vals.size(), 64);
    for (int i = 0; i < 64 && i < pt_vals.size(); i++) check("pt_f0_data", pt_vals[i], i + 1);
    for (int i = 65; i <= 96; i++) send(16'(i));
    repeat (100) @(negedge clk);
    check("pt_f1_len", pt_vals.size(), 128);
    for (int i = 0; i < 64 && 64 + i < pt_vals.size(); i++)
      check("pt_f1_data", pt_vals[64 + i], 33 + i);

    // Hamming window
    do_reset();
    for (int i = 0; i < 64; i++) send(16'sh4000);
    repeat (100) @(negedge clk);
    check("win_f0_len", win_vals.size(), 64);
    if (win_vals.size() >= 64) begin
      check("win_first", win_vals[0], 1311);
      check("win_last", win_vals[63], 1311);
      check("win_mid31", win_vals[31], 16374);
      check("win_mid32", win_vals[32], 16374);
      for (int k = 0; k < 32; k++) check("win_symm", win_vals[k], win_vals[63 - k]);
    end
    for (int i = 0; i < 64; i++) send(-16'sd16384);
    repeat (200) @(negedge clk);
    check("win_f2_len", win_vals.size(), 192);
    if (win_vals.size() >= 192) begin
      check("win_f1_first", win_vals[64], 1311);
      check("win_f1_last", win_vals[127], -1310);
      check("win_neg_first", win_vals[128], -1310);
      check("win_neg_mid", win_vals[159], -16374);
      check("win_neg_last", win_vals[191], -1310);
    end

    // Back-pressure: valid every cycle regardless of ready
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 16'(c + 1);
    end
    @(negedge clk);
    s_valid = 1'b0;
    repeat (300) @(negedge clk);
    check("bp_ovf_sticky", int'(pt_ovf), 1);
    na = acc_q.size();
    nf = (na >= N) ? (na - N) / HOP + 1 : 0;
    check("bp_frames", pt_vals.size(), nf * N);
    for (int f = 0; f < nf; f++)
      for (int i = 0; i < N && N * f + i < pt_vals.size(); i++)
        check("bp_data", pt_vals[N * f + i], acc_q[HOP * f + i]);
    do_reset();
    @(negedge clk);
    check("ovf_cleared", int'(pt_ovf), 0);

    // Pointer wrap: 1000 samples, one per 3 cycles
    for (int v = 1; v <= 1000; v++) begin
      send(16'(v));
      repeat (2) @(negedge clk);
    end
    repeat (150) @(negedge clk);
    check("wrap_accepted", acc_q.size(), 1000);
    check("wrap_len", pt_vals.size(), 30 * N);
    for (int f = 0; f < 30; f++)
      for (int i = 0; i < N && N * f + i < pt_vals.size(); i++)
        check("wrap_data", pt_vals[N * f + i], HOP * f + i + 1);

    // Reset mid-burst
    do_reset();
    for (int i = 0; i < 64; i++) send(16'(2000 + i));
    n = 0;
    while (!pt_en && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("rst_burst_seen", int'(pt_en), 1);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_en_low", int'(pt_en), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 63; i++) send(16'(3000 + i));
    repeat (100) @(negedge clk);
    check("rst_no_frame_63", pt_vals.size(), 0);
    send(16'sd3063);
    repeat (100) @(negedge clk);
    check("rst_frame_len", pt_vals.size(), 64);
    if (pt_vals.size() >= 64) begin
      check("rst_frame_first", pt_vals[0], 3000);
      check("rst_frame_last", pt_vals[63], 3063);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/frame_windower.md
Name: frame_windower

Overview:
- Upstream feeder of the radix-2^2 SDF FFT chain.
- Accepts a stream of real audio samples and holds them in an overlapping frame buffer (frame N, hop HOP).
- Applies a Hamming window and emits each frame as one contiguous N-cycle burst (do_en/do_re/do_im) in the format the first SDF stage consumes.
- Guarantees at least one do_en-low cycle between frames so the downstream input counter restarts per frame.

Parameters:
- N, 64, frame length / FFT points (power of 2, >=4)
- HOP, 32, new samples per frame (power of 2, 1..N)
- WIDTH, 16, sample/output data width (signed two's complement)
- WIN_EN, 1, 1 = apply Hamming window; 0 = coefficient fixed at 1.0 (pass-through)

Ports:
- clock  in  1  master clock
- reset  in  1  synchronous, active-low reset
- s_valid  in  1  input sample valid
- s_data  in  WIDTH  input sample (signed)
- s_ready  out  1  block can accept a sample this cycle
- do_en  out  1  output data enable; high for exactly N consecutive cycles per frame
- do_re  out  WIDTH  windowed sample (real)
- do_im  out  WIDTH  always 0
- do_start  out  1  one-cycle pulse coincident with the first do_en of each frame
- ovf  out  1  sticky: s_valid seen while s_ready low

Behaviour:
- Reset (reset==0 at a posedge) applies to all state:
  - wr_ptr, rd_base, occupancy cleared to 0; FSM to IDLE.
  - do_en, do_start, ovf, do_re, do_im = 0 from the next cycle.
  - The pipeline is flushed; an in-progress frame is abandoned, with no partial burst after reset.
- Storage:
  - Circular RAM, depth D = N+HOP, registered read (1-cycle latency).
  - Pointers wrap modulo D; D need not be a power of 2, so wrap is explicit.
- Write side:
  - s_ready = (occupancy < D), combinational from registered occupancy.
  - A write occurs when s_valid & s_ready: store at wr_ptr, wr_ptr++.
  - s_valid & !s_ready drops the sample and sets ovf (sticky until reset).
- FSM, IDLE -> EMIT -> IDLE:
  - IDLE: if occupancy >= N, go to EMIT with read index k=0.
  - EMIT: issue a read at (rd_base+k) mod D, k = 0..N-1, one per cycle, no stalls. At k=N-1, go to IDLE, rd_base += HOP (mod D), and release HOP entries.
- Occupancy update:
  - Simultaneous write and release in one cycle: occupancy = occupancy + 1 - HOP.
  - Writes are permitted throughout EMIT. Entries being read are never overwritten, because they are the oldest N and occupancy < D.
- Timing:
  - Trigger seen in IDLE at cycle T; reads occur in cycles T+1..T+N.
  - RAM output at T+2..T+N+1; windowed result registered, do_en high in T+3..T+N+2.
  - do_start high in T+3 only.
  - Fixed latency: 2 cycles from read issue to do_en.
  - The earliest next frame has do_en high again at T+N+4, leaving at least 1 low cycle.
- Window:
  - Coefficient ROM w[k] = round(32767*(0.54-0.46*cos(2*pi*k/(N-1)))), unsigned Q1.15, indexed by k.
  - The ROM read is aligned with the RAM read (same cycle).
  - WIN_EN=0: the multiply is bypassed and do_re = sample exactly.
- Arithmetic:
  - Product = signed sample × {0,w}, 32-bit signed.
  - do_re = (product + 2^14) >>> 15, arithmetic shift (round half up), truncated to WIDTH.
  - Saturation is not required because w < 1.0.
- do_re/do_im when do_en low:
  - These outputs are don't-care for functional checks.
  - The implementation holds 0 to reduce toggling.
- First frame: needs N samples. Each subsequent frame needs HOP more samples.
- Output never stalls: there is no downstream ready; the FFT consumes every do_en cycle.

Test Plan:
- Reset/idle: hold reset low 5 cycles, then release with s_valid=0 -> s_ready=1, do_en=0, ovf=0 indefinitely.
- Pass-through, WIN_EN=0, N=64, HOP=32: feed samples 1..64 back-to-back -> one 64-cycle do_en burst with do_re=1..64, do_im=0, and do_start pulse on value 1. Feed 32 more samples (65..96) -> second burst 33..96. Exactly 1+ low cycle between bursts.
- Window, WIN_EN=1: feed 64 samples of 0x4000 -> do_re[0]=1311 (w[0]=2621), do_re[63]=1311, burst symmetric (do_re[k]==do_re[63-k]). Feed 64 samples of 0xC000 -> do_re[0]=-1310.
- Back-pressure/overflow: s_valid=1 continuously, 1 sample/cycle, no gaps -> s_ready drops when occupancy=96. Drops set ovf=1, which stays 1 until reset. Emitted frames remain contiguous and correct for accepted samples.
- Pointer wrap: stream 1000 incrementing samples at 1 sample per 3 cycles -> every burst k contains samples 32k+1..32k+64 exactly; no duplicates or skips across D=96 wrap.
- Reset mid-burst: assert reset at burst cycle 20 -> do_en low on the next cycle, no remaining burst. After release, the first frame again requires 64 fresh samples.
